// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Register index type, r0 constant, FSM states and the RAW match helper.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   // r0 is hardwired to zero, so it never carries a dependency
   function automatic logic dep_hit(
      input reg_idx_t dest,
      input reg_idx_t src
   );
      return (dest != REG_ZERO) && (dest == src);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_raw.sv
// Source/destination comparator for RAW hazards seen from ID.
// FORWARDING=0 widens the check to any EXE or MEM writer.
import hazard_pkg::*;

module haz_raw_detect #(
   parameter int FORWARDING = 1
) (
   input  logic [4:0] id_src1,
   input  logic [4:0] id_src2,
   input  logic       id_two_src,
   input  logic [4:0] exe_dest,
   input  logic       exe_wb_en,
   input  logic       exe_mem_r_en,
   input  logic [4:0] mem_dest,
   input  logic       mem_wb_en,
   output logic       hazard
);

   logic exe_hit;
   logic mem_hit;
   logic load_use;
   logic raw_any;

   assign exe_hit = dep_hit(exe_dest, id_src1)
                  | (id_two_src & dep_hit(exe_dest, id_src2));
   assign mem_hit = dep_hit(mem_dest, id_src1)
                  | (id_two_src & dep_hit(mem_dest, id_src2));

   assign load_use = exe_mem_r_en & exe_wb_en & exe_hit;
   assign raw_any  = (exe_wb_en & exe_hit) | (mem_wb_en & mem_hit);

   assign hazard = (FORWARDING != 0) ? load_use : (load_use | raw_any);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/flush controller: load-use stalls, branch squash, memory-wait watchdog.
// Define HAZ_PERF_CNT_EN to add stall/flush/load-use performance counters.
import hazard_pkg::*;

module pipeline_hazard_ctrl #(
   parameter int FORWARDING  = 1,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_src1,
   input  logic [4:0] id_src2,
   input  logic       id_two_src,
   input  logic [4:0] exe_dest,
   input  logic       exe_wb_en,
   input  logic       exe_mem_r_en,
   input  logic [4:0] mem_dest,
   input  logic       mem_wb_en,
   input  logic       br_taken,
   input  logic       mem_busy,
   output logic       pc_hold,
   output logic       ifid_hold,
   output logic       ifid_flush,
   output logic       idex_hold,
   output logic       idex_flush,
   output logic       exmem_hold,
   output logic       memwb_bubble,
   output logic       mem_timeout,
   output logic       err_sticky
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] lu_cnt
`endif
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          err_q;
   logic          hazard;
   logic          stall_all;
   logic          tmo_hit;
   logic          br_flush;
   logic          lu_stall;

   haz_raw_detect #(
      .FORWARDING (FORWARDING)
   ) u_raw (
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .hazard       (hazard)
   );

   assign stall_all = rst & mem_busy
                    & ((state == RUN) | (cnt < TMO));
   assign tmo_hit   = rst & mem_busy
                    & (state == MEM_WAIT) & (cnt == TMO);
   assign br_flush  = rst & ~stall_all & br_taken;
   assign lu_stall  = rst & ~stall_all & ~br_taken & hazard;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (tmo_hit) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               state_nxt = MEM_WAIT;
               cnt_nxt   = CW'(1);
            end
         end
         MEM_WAIT: begin
            if (!mem_busy || cnt == TMO) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // memory stall outranks branch, branch squashes load-use
   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      ifid_flush   = 1'b0;
      idex_hold    = 1'b0;
      idex_flush   = 1'b0;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b0;
      priority case (1'b1)
         stall_all: begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
         end
         br_flush: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end
         lu_stall: begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_timeout = tmo_hit;
   assign err_sticky  = rst & err_q;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         lu_cnt    <= '0;
      end else begin
         if (pc_hold)  stall_cnt <= stall_cnt + 32'd1;
         if (br_flush) flush_cnt <= flush_cnt + 32'd1;
         if (lu_stall) lu_cnt    <= lu_cnt + 32'd1;
      end
   end
`endif

endmodule
